// File: rtl/ntt_stage_addr_gen.sv
// Per-stage NTT butterfly scheduler: two butterflies per beat, N/4 beats per pass, zeta_valid one cycle after each accept.
// Outputs are registered and valid one cycle after start; they are held bit-stable while out_ready is low.
module ntt_stage_addr_gen #(
    parameter int NTT_STAGE_CNT = 8,
    parameter int STAGE         = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [NTT_STAGE_CNT-1:0] idx_a    [2],
    output logic [NTT_STAGE_CNT-1:0] idx_b    [2],
    output logic [NTT_STAGE_CNT-2:0] rom_addr [2],
    output logic                     zeta_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int W  = NTT_STAGE_CNT;
    localparam int KW = W - 2;
    localparam int SH = W - 1 - STAGE;

    localparam logic [W-1:0]  LEN    = W'(1) << SH;
    // At STAGE 0 this wraps to zero, so the mask becomes all ones and the offset is j itself.
    localparam logic [W-2:0]  LEN1   = (W-1)'(1) << SH;
    localparam logic [W-2:0]  OMASK  = LEN1 - (W-1)'(1);
    localparam logic [KW-1:0] K_LAST = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [KW-1:0] k_load;
    logic          accept;
    logic          last;

    logic [W-2:0]  jv    [2];
    logic [W-2:0]  gv    [2];
    logic [W-1:0]  a_nxt [2];
    logic [W-1:0]  b_nxt [2];
    logic [W-2:0]  r_nxt [2];

    assign accept = out_valid & out_ready;
    assign last   = (k == K_LAST);
    assign done   = accept & last;
    assign k_load = (state == RUN) ? k + KW'(1) : '0;

    // Index pair for the beat about to be presented: j = 2k+lane, split into group and offset.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            jv[l]    = {k_load, l[0]};
            gv[l]    = jv[l] >> SH;
            a_nxt[l] = ({1'b0, gv[l]} << (SH + 1)) | {1'b0, jv[l] & OMASK};
            b_nxt[l] = a_nxt[l] + LEN;
            r_nxt[l] = gv[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            zeta_valid <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                idx_a[l]    <= '0;
                idx_b[l]    <= '0;
                rom_addr[l] <= '0;
            end
        end else begin
            zeta_valid <= accept;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        k         <= '0;
                        for (int l = 0; l < 2; l++) begin
                            idx_a[l]    <= a_nxt[l];
                            idx_b[l]    <= b_nxt[l];
                            rom_addr[l] <= r_nxt[l];
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            k         <= '0;
                            for (int l = 0; l < 2; l++) begin
                                idx_a[l]    <= '0;
                                idx_b[l]    <= '0;
                                rom_addr[l] <= '0;
                            end
                        end else begin
                            k <= k_load;
                            for (int l = 0; l < 2; l++) begin
                                idx_a[l]    <= a_nxt[l];
                                idx_b[l]    <= b_nxt[l];
                                rom_addr[l] <= r_nxt[l];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_stage_addr_gen.sv
// Directed bench for ntt_stage_addr_gen: four instances (STAGE 0, 7, 3, 5) driven by shared handshake inputs.
module tb_ntt_stage_addr_gen;

    localparam int W     = 8;
    localparam int BEATS = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;

    logic [W-1:0] ia [4][2];
    logic [W-1:0] ib [4][2];
    logic [W-2:0] ra [4][2];
    logic         ov [4];
    logic         zv [4];
    logic         bz [4];
    logic         dn [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ntt_stage_addr_gen #(.NTT_STAGE_CNT(W), .STAGE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready), .out_valid(ov[0]),
        .idx_a(ia[0]), .idx_b(ib[0]), .rom_addr(ra[0]), .zeta_valid(zv[0]), .busy(bz[0]), .done(dn[0]));
    ntt_stage_addr_gen #(.NTT_STAGE_CNT(W), .STAGE(7)) u_s7 (
        .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready), .out_valid(ov[1]),
        .idx_a(ia[1]), .idx_b(ib[1]), .rom_addr(ra[1]), .zeta_valid(zv[1]), .busy(bz[1]), .done(dn[1]));
    ntt_stage_addr_gen #(.NTT_STAGE_CNT(W), .STAGE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready), .out_valid(ov[2]),
        .idx_a(ia[2]), .idx_b(ib[2]), .rom_addr(ra[2]), .zeta_valid(zv[2]), .busy(bz[2]), .done(dn[2]));
    ntt_stage_addr_gen #(.NTT_STAGE_CNT(W), .STAGE(5)) u_s5 (
        .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready), .out_valid(ov[3]),
        .idx_a(ia[3]), .idx_b(ib[3]), .rom_addr(ra[3]), .zeta_valid(zv[3]), .busy(bz[3]), .done(dn[3]));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int stage_of(input int u);
        case (u)
            0: return 0;
            1: return 7;
            2: return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int m_len(input int st);
        return 256 >> (st + 1);
    endfunction

    function automatic int m_g(input int st, input int beat, input int lane);
        return (2 * beat + lane) / m_len(st);
    endfunction

    function automatic int m_a(input int st, input int beat, input int lane);
        return m_g(st, beat, lane) * 2 * m_len(st) + (2 * beat + lane) % m_len(st);
    endfunction

    task automatic check_zero(input string tag);
        for (int u = 0; u < 4; u++) begin
            check($sformatf("%s_valid_u%0d", tag, u), ov[u], 0);
            check($sformatf("%s_busy_u%0d", tag, u), bz[u], 0);
            check($sformatf("%s_zeta_u%0d", tag, u), zv[u], 0);
            check($sformatf("%s_done_u%0d", tag, u), dn[u], 0);
            for (int l = 0; l < 2; l++) begin
                check($sformatf("%s_a_u%0d_l%0d", tag, u, l), ia[u][l], 0);
                check($sformatf("%s_b_u%0d_l%0d", tag, u, l), ib[u][l], 0);
                check($sformatf("%s_rom_u%0d_l%0d", tag, u, l), ra[u][l], 0);
            end
        end
    endtask

    task automatic check_beat(input int beat);
        for (int u = 0; u < 4; u++) begin
            int st;
            st = stage_of(u);
            check($sformatf("valid_u%0d_k%0d", u, beat), ov[u], 1);
            check($sformatf("busy_u%0d_k%0d", u, beat), bz[u], 1);
            for (int l = 0; l < 2; l++) begin
                check($sformatf("a_u%0d_l%0d_k%0d", u, l, beat), ia[u][l], m_a(st, beat, l));
                check($sformatf("b_u%0d_l%0d_k%0d", u, l, beat), ib[u][l], m_a(st, beat, l) + m_len(st));
                check($sformatf("rom_u%0d_l%0d_k%0d", u, l, beat), ra[u][l], m_g(st, beat, l));
            end
        end
    endtask

    // Hand-derived values for the corner beats of stages 0, 7 and 3.
    task automatic directed(input int beat);
        if (beat == 0) begin
            check("s0_k0_a0", ia[0][0], 0);   check("s0_k0_a1", ia[0][1], 1);
            check("s0_k0_b0", ib[0][0], 128); check("s0_k0_b1", ib[0][1], 129);
            check("s0_k0_r0", ra[0][0], 0);   check("s0_k0_r1", ra[0][1], 0);
            check("s7_k0_a0", ia[1][0], 0);   check("s7_k0_a1", ia[1][1], 2);
            check("s7_k0_b0", ib[1][0], 1);   check("s7_k0_b1", ib[1][1], 3);
            check("s7_k0_r0", ra[1][0], 0);   check("s7_k0_r1", ra[1][1], 1);
        end
        if (beat == 8) begin
            check("s3_k8_a0", ia[2][0], 32);  check("s3_k8_a1", ia[2][1], 33);
            check("s3_k8_b0", ib[2][0], 48);  check("s3_k8_b1", ib[2][1], 49);
            check("s3_k8_r0", ra[2][0], 1);   check("s3_k8_r1", ra[2][1], 1);
        end
        if (beat == 15) begin
            check("s3_k15_a0", ia[2][0], 46); check("s3_k15_a1", ia[2][1], 47);
            check("s3_k15_b0", ib[2][0], 62); check("s3_k15_b1", ib[2][1], 63);
            check("s3_k15_r0", ra[2][0], 1);  check("s3_k15_r1", ra[2][1], 1);
        end
        if (beat == 63) begin
            check("s0_k63_a0", ia[0][0], 126); check("s0_k63_a1", ia[0][1], 127);
            check("s0_k63_b0", ib[0][0], 254); check("s0_k63_b1", ib[0][1], 255);
            check("s7_k63_a0", ia[1][0], 252); check("s7_k63_a1", ia[1][1], 254);
            check("s7_k63_b0", ib[1][0], 253); check("s7_k63_b1", ib[1][1], 255);
            check("s7_k63_r0", ra[1][0], 126); check("s7_k63_r1", ra[1][1], 127);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_pass(input int stall_pct, input int abort_at, input bit start_mid,
                            input bit start_last, input bit pre_started);
        int beat;
        int cyc;
        int zcnt;
        int dcnt;
        bit acc_prev;
        beat = 0; cyc = 0; zcnt = 0; dcnt = 0; acc_prev = 1'b0;
        if (!pre_started) begin
            start = 1'b1;
            out_ready = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        while (beat < BEATS && cyc < 1000) begin
            out_ready = ($urandom_range(99) >= stall_pct) || (start_last && beat == BEATS - 1);
            start = (start_mid && beat == 10) || (start_last && beat == BEATS - 1);
            if (beat == abort_at) begin
                out_ready = 1'b0;
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            check_beat(beat);
            directed(beat);
            for (int u = 0; u < 4; u++) begin
                check($sformatf("done_u%0d_k%0d", u, beat), dn[u], int'(out_ready && beat == BEATS - 1));
                check($sformatf("zeta_u%0d_k%0d", u, beat), zv[u], int'(acc_prev));
            end
            zcnt += int'(zv[3]);
            dcnt += int'(dn[3]);
            acc_prev = out_ready;
            if (out_ready) beat++;
            @(posedge clk); #1;
            cyc++;
        end
        check("beat_budget", beat, BEATS);
        start = start_last;
        out_ready = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            check($sformatf("end_valid_u%0d", u), ov[u], 0);
            check($sformatf("end_busy_u%0d", u), bz[u], 0);
            check($sformatf("end_zeta_u%0d", u), zv[u], 1);
            check($sformatf("end_done_u%0d", u), dn[u], 0);
        end
        zcnt += int'(zv[3]);
        check("zeta_count", zcnt, BEATS);
        check("done_count", dcnt, 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // out_ready alone must not start anything.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_valid", ov[0], 0);
            check("idle_busy", bz[0], 0);
            check("idle_zeta", zv[0], 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;

        run_pass(0, -1, 1'b0, 1'b0, 1'b0);
        run_pass(30, -1, 1'b1, 1'b1, 1'b0);
        run_pass(0, -1, 1'b0, 1'b0, 1'b1);
        run_pass(20, 20, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_abort_valid", ov[3], 0);
        check("post_abort_busy", bz[3], 0);
        @(posedge clk); #1;
        run_pass(0, -1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
